// File: rtl/inst_phase_sequencer_pkg.sv
// Shared phase encodings and instruction field positions for the
// instruction phase sequencer, decoder and ALU.
package inst_phase_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      GAP      = 3'd2,
      DECODE   = 3'd3,
      EXEC     = 3'd4,
      WRITE    = 3'd5,
      WAIT_REL = 3'd6
   } phase_e;

   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 4;
   localparam int OPR_MSB = 3;
   localparam int OPR_LSB = 0;

   function automatic phase_e after_gap(phase_e p);
      case (p)
         FETCH:   return DECODE;
         DECODE:  return EXEC;
         default: return WRITE;
      endcase
   endfunction

   function automatic logic [3:0] opcode(logic [7:0] inst);
      return inst[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [3:0] operand(logic [7:0] inst);
      return inst[OPR_MSB:OPR_LSB];
   endfunction

endpackage

// File: rtl/inst_phase_sequencer_switch_debouncer.sv
// Two-flop synchroniser plus stable-count debouncer for a raw switch.
// released flags a genuine low level once the synchroniser has refilled.
module switch_debouncer #(
   parameter logic [15:0] DB_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic level,
   output logic released
);

   logic        s1;
   logic        s2;
   logic [15:0] cnt;
   logic [1:0]  prime;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         level <= 1'b0;
         cnt   <= 16'd0;
         prime <= 2'd0;
      end else begin
         s1 <= sw;
         s2 <= s1;
         if (prime != 2'd2)
            prime <= prime + 2'd1;
         if (s2 == level)
            cnt <= 16'd0;
         else if (cnt == DB_CYCLES - 16'd1) begin
            level <= ~level;
            cnt   <= 16'd0;
         end else
            cnt <= cnt + 16'd1;
      end
   end

   // zeros left in the synchroniser by reset are not a real release
   assign released = ~level & ~s2 & prime[1];

endmodule

// File: rtl/inst_phase_sequencer.sv
// Single-clock fetch/decode/exec/write enable sequencer for the switch CPU.
// Optional INST_CNT output is enabled by defining INST_PHASE_SEQ_CNT_EN.
module inst_phase_sequencer
   import inst_phase_sequencer_pkg::*;
#(
   parameter logic [15:0] DB_CYCLES = 16'd50000,
   parameter logic [1:0]  PHASE_GAP = 2'd1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       SW_START,
   input  logic [7:0] SW_INST,
   output logic [7:0] INST,
   output logic       DEC_EN,
   output logic       ALU_EN,
   output logic       WRI_EN,
   output logic       BUSY,
   output logic [2:0] PHASE
`ifdef INST_PHASE_SEQ_CNT_EN
  ,output logic [7:0] INST_CNT
`endif
);

   logic       db_level;
   logic       db_released;
   logic       armed;
   logic       press;
   logic [1:0] gap_cnt;
   phase_e     state;
   phase_e     nxt;
   phase_e     gap_to;

   switch_debouncer #(
      .DB_CYCLES(DB_CYCLES)
   ) u_start_db (
      .clk     (CLK),
      .rst_n   (RST_N),
      .sw      (SW_START),
      .level   (db_level),
      .released(db_released)
   );

   assign press = db_level & armed;
   assign PHASE = state;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:     if (press) nxt = FETCH;
         FETCH,
         DECODE,
         EXEC:     nxt = (PHASE_GAP == 2'd0) ? after_gap(state) : GAP;
         GAP:      if (gap_cnt == PHASE_GAP - 2'd1) nxt = gap_to;
         WRITE:    nxt = WAIT_REL;
         WAIT_REL: if (!db_level) nxt = IDLE;
         default:  nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state   <= IDLE;
         gap_to  <= IDLE;
         gap_cnt <= 2'd0;
         armed   <= 1'b0;
         INST    <= 8'h00;
         DEC_EN  <= 1'b0;
         ALU_EN  <= 1'b0;
         WRI_EN  <= 1'b0;
         BUSY    <= 1'b0;
      end else begin
         state  <= nxt;
         DEC_EN <= (nxt == DECODE);
         ALU_EN <= (nxt == EXEC);
         WRI_EN <= (nxt == WRITE);
         BUSY   <= (nxt != IDLE) && (nxt != WAIT_REL);
         if (press)
            armed <= 1'b0;
         else if (db_released)
            armed <= 1'b1;
         if (state == FETCH)
            INST <= SW_INST;
         if (state == FETCH || state == DECODE || state == EXEC) begin
            gap_to  <= after_gap(state);
            gap_cnt <= 2'd0;
         end else if (state == GAP)
            gap_cnt <= gap_cnt + 2'd1;
      end
   end

`ifdef INST_PHASE_SEQ_CNT_EN
   always_ff @(posedge CLK) begin
      if (!RST_N)
         INST_CNT <= 8'h00;
      else if (state == WRITE)
         INST_CNT <= INST_CNT + 8'h01;
   end
`endif

endmodule

// File: tb/tb_inst_phase_sequencer.sv
// Randomised bench for inst_phase_sequencer, gap 1 and gap 0 instances
// side by side against a timeline model of the press/phase rules.
module tb_inst_phase_sequencer;

   localparam int DBI = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sw_start = 1'b0;
   logic [7:0] sw_inst = 8'h00;

   logic [7:0] inst_o [2];
   logic       dec_o  [2];
   logic       alu_o  [2];
   logic       wri_o  [2];
   logic       busy_o [2];
   logic [2:0] phase_o[2];
`ifdef INST_PHASE_SEQ_CNT_EN
   logic [7:0] cnt_o  [2];
`endif

   int gval[2] = '{1, 0};

   int errs = 0;
   int checks = 0;

   bit   m_s1, m_s2, m_lvl, m_arm;
   int   m_prime;
   bit   win[$];
   int   m_mode[2];
   int   m_off[2];
   logic [7:0] m_inst[2];
   logic [7:0] m_cnt[2];
   int   wri_seen[2];
   int   busy_seen[2];

   always #5 clk = ~clk;

   inst_phase_sequencer #(
      .DB_CYCLES(16'd4),
      .PHASE_GAP(2'd1)
   ) dut_g1 (
      .CLK     (clk),
      .RST_N   (rst_n),
      .SW_START(sw_start),
      .SW_INST (sw_inst),
      .INST    (inst_o[0]),
      .DEC_EN  (dec_o[0]),
      .ALU_EN  (alu_o[0]),
      .WRI_EN  (wri_o[0]),
      .BUSY    (busy_o[0]),
      .PHASE   (phase_o[0])
`ifdef INST_PHASE_SEQ_CNT_EN
     ,.INST_CNT(cnt_o[0])
`endif
   );

   inst_phase_sequencer #(
      .DB_CYCLES(16'd4),
      .PHASE_GAP(2'd0)
   ) dut_g0 (
      .CLK     (clk),
      .RST_N   (rst_n),
      .SW_START(sw_start),
      .SW_INST (sw_inst),
      .INST    (inst_o[1]),
      .DEC_EN  (dec_o[1]),
      .ALU_EN  (alu_o[1]),
      .WRI_EN  (wri_o[1]),
      .BUSY    (busy_o[1]),
      .PHASE   (phase_o[1])
`ifdef INST_PHASE_SEQ_CNT_EN
     ,.INST_CNT(cnt_o[1])
`endif
   );

   task automatic check(string tag, int got, int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // the sequence is a fixed timeline measured from the press event
   function automatic int exp_phase(int g);
      int gg;
      gg = gval[g];
      if (m_mode[g] == 0) return 0;
      if (m_mode[g] == 2) return 6;
      if (m_off[g] == 1) return 1;
      if (m_off[g] == 2 + gg) return 3;
      if (m_off[g] == 3 + 2 * gg) return 4;
      if (m_off[g] == 4 + 3 * gg) return 5;
      return 2;
   endfunction

   task automatic model_edge();
      bit lvl0, s20, press, all;
      int gg;
      lvl0 = m_lvl;
      s20 = m_s2;
      press = lvl0 && m_arm;
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_lvl = 0; m_arm = 0; m_prime = 0;
         win.delete();
         for (int g = 0; g < 2; g++) begin
            m_mode[g] = 0; m_off[g] = 0;
            m_inst[g] = 8'h00; m_cnt[g] = 8'h00;
         end
         return;
      end
      for (int g = 0; g < 2; g++) begin
         gg = gval[g];
         case (m_mode[g])
            0: if (press) begin
                  m_mode[g] = 1;
                  m_off[g] = 1;
               end
            1: begin
                  if (m_off[g] == 1) m_inst[g] = sw_inst;
                  if (m_off[g] == 4 + 3 * gg) begin
                     m_cnt[g] = m_cnt[g] + 8'd1;
                     m_mode[g] = 2;
                  end else
                     m_off[g]++;
               end
            default: if (!lvl0) m_mode[g] = 0;
         endcase
      end
      if (press) m_arm = 0;
      else if (!lvl0 && !s20 && m_prime >= 2) m_arm = 1;
      win.push_back(s20);
      if (win.size() > DBI) void'(win.pop_front());
      all = (win.size() == DBI);
      foreach (win[i]) if (win[i] == lvl0) all = 0;
      if (all) begin
         m_lvl = !lvl0;
         win.delete();
      end
      m_s2 = m_s1;
      m_s1 = sw_start;
      if (m_prime < 2) m_prime++;
   endtask

   task automatic compare();
      int gg;
      bit run;
      for (int g = 0; g < 2; g++) begin
         gg = gval[g];
         run = (m_mode[g] == 1);
         check($sformatf("inst_g%0d", gg), inst_o[g], m_inst[g]);
         check($sformatf("dec_g%0d", gg), dec_o[g], run && m_off[g] == 2 + gg);
         check($sformatf("alu_g%0d", gg), alu_o[g], run && m_off[g] == 3 + 2 * gg);
         check($sformatf("wri_g%0d", gg), wri_o[g], run && m_off[g] == 4 + 3 * gg);
         check($sformatf("busy_g%0d", gg), busy_o[g], run);
         check($sformatf("phase_g%0d", gg), phase_o[g], exp_phase(g));
`ifdef INST_PHASE_SEQ_CNT_EN
         check($sformatf("cnt_g%0d", gg), cnt_o[g], m_cnt[g]);
`endif
         wri_seen[g] += int'(wri_o[g]);
         busy_seen[g] += int'(busy_o[g]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare();
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic bounce(int n);
      repeat (n) begin
         sw_start = 1'($urandom);
         tick();
      end
   endtask

   task automatic clear_seen();
      for (int g = 0; g < 2; g++) begin
         wri_seen[g] = 0;
         busy_seen[g] = 0;
      end
   endtask

   initial begin
      int i;
      sw_inst = 8'h3A;
      rst_n = 1'b0;
      idle(3);
      check("rst_inst", inst_o[0], 8'h00);
      check("rst_busy", busy_o[0], 0);
      check("rst_phase", phase_o[1], 0);
      rst_n = 1'b1;
      idle(6);

      clear_seen();
      sw_start = 1'b1;
      idle(10);
      sw_inst = 8'h55;
      sw_start = 1'b0;
      idle(1);
      sw_start = 1'b1;
      idle(10);
      sw_start = 1'b0;
      idle(14);
      check("clean_inst", inst_o[0], 8'h3A);
      check("clean_wri", wri_seen[0], 1);
      check("clean_busy_len", busy_seen[0], 7);
      check("clean_busy_len_g0", busy_seen[1], 4);

      clear_seen();
      sw_start = 1'b1;
      idle(2);
      sw_start = 1'b0;
      idle(12);
      check("glitch_busy", busy_seen[0], 0);
      check("glitch_inst", inst_o[1], 8'h3A);

      clear_seen();
      sw_inst = 8'hC7;
      sw_start = 1'b1;
      idle(100);
      check("hold_wri_g1", wri_seen[0], 1);
      check("hold_wri_g0", wri_seen[1], 1);
      sw_start = 1'b0;
      idle(12);
      sw_inst = 8'h96;
      sw_start = 1'b1;
      idle(20);
      sw_start = 1'b0;
      idle(12);
      check("repress_wri", wri_seen[0], 2);
      check("repress_inst", inst_o[0], 8'h96);

      sw_start = 1'b1;
      i = 0;
      while (i < 60 && !(m_mode[0] == 1 && m_off[0] == 5)) begin
         tick();
         i++;
      end
      check("exec_reached", phase_o[0], 4);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rst_exec_inst", inst_o[0], 8'h00);
      check("rst_exec_alu", alu_o[0], 0);
      check("rst_exec_wri", wri_o[0], 0);
      clear_seen();
      idle(30);
      check("held_no_run", busy_seen[0] + busy_seen[1], 0);
      sw_start = 1'b0;
      idle(12);
      sw_start = 1'b1;
      idle(16);
      sw_start = 1'b0;
      idle(12);
      check("after_rst_run", wri_seen[0], 1);

      for (int k = 0; k < 40; k++) begin
         sw_inst = 8'($urandom);
         bounce($urandom_range(0, 3));
         sw_start = 1'b1;
         idle($urandom_range(1, 12));
         if ($urandom_range(0, 7) == 0) begin
            rst_n = 1'b0;
            idle($urandom_range(1, 2));
            rst_n = 1'b1;
         end
         bounce($urandom_range(0, 3));
         sw_start = 1'b0;
         idle($urandom_range(0, 12));
      end
      sw_start = 1'b0;
      idle(12);

      clear_seen();
      for (int k = 0; k < 256; k++) begin
         sw_inst = 8'($urandom);
         bounce($urandom_range(0, 2));
         sw_start = 1'b1;
         idle($urandom_range(6, 20));
         bounce($urandom_range(0, 2));
         sw_start = 1'b0;
         idle($urandom_range(8, 14));
      end
      idle(10);
      check("runs256_g1", wri_seen[0], 256);
      check("runs256_g0", wri_seen[1], 256);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
